// File: rtl/rf_read_port_arbiter.sv
// Round-robin arbiter sharing one register-file read port among NREQ requesters,
// with a single-entry response register under a valid/ready handshake.
module rf_read_port_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 2,
  parameter int NREQ   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  output logic [NREQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]      mux_addr,
  input  logic [DATA_W-1:0]      mux_data,
  output logic                   rsp_valid,
  output logic [1:0]             rsp_id,
  output logic [ADDR_W-1:0]      rsp_addr,
  output logic [DATA_W-1:0]      rsp_data,
  input  logic                   rsp_ready,
  output logic [7:0]             busy_cnt
);

  localparam int ID_W = 2;

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t              r_state, w_state_nxt;
  logic [ID_W-1:0]     r_last_grant;
  logic [ID_W-1:0]     w_winner, w_idx;
  logic [ADDR_W-1:0]   r_mux_addr, w_win_addr;
  logic [ADDR_W-1:0]   r_rsp_addr;
  logic [1:0]          r_rsp_id;
  logic [DATA_W-1:0]   r_rsp_data;
  logic [7:0]          r_busy_cnt;
  logic [NREQ-1:0]     w_ready;
  logic                w_slot_free, w_grant;

  assign rsp_valid   = (r_state == S_FULL);
  assign w_slot_free = !rsp_valid || rsp_ready;

  // Search starts just past the last winner so every requester gets a turn.
  always_comb begin
    w_grant  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = r_last_grant + ID_W'(k);
      if (!w_grant && w_slot_free && req_valid[w_idx]) begin
        w_grant  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_win_addr = req_addr[w_winner*ADDR_W +: ADDR_W];
  assign w_ready    = w_grant ? (NREQ'(1) << w_winner) : '0;

  // Outputs are forced quiet while reset is held, even if requests are pending.
  assign req_ready = rst_n ? w_ready : '0;
  assign mux_addr  = !rst_n ? '0 : (w_grant ? w_win_addr : r_mux_addr);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_grant) w_state_nxt = S_FULL;
      S_FULL:  if (rsp_ready && !w_grant) w_state_nxt = S_EMPTY;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_EMPTY;
      r_last_grant <= ID_W'(NREQ - 1);
      r_mux_addr   <= '0;
      r_rsp_id     <= '0;
      r_rsp_addr   <= '0;
      r_rsp_data   <= '0;
      r_busy_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_last_grant <= w_winner;
        r_mux_addr   <= w_win_addr;
        r_rsp_id     <= w_winner;
        r_rsp_addr   <= w_win_addr;
        r_rsp_data   <= mux_data;
      end
      if (|req_valid && !w_slot_free && r_busy_cnt != 8'hFF)
        r_busy_cnt <= r_busy_cnt + 8'd1;
    end
  end

  assign rsp_id   = r_rsp_id;
  assign rsp_addr = r_rsp_addr;
  assign rsp_data = r_rsp_data;
  assign busy_cnt = r_busy_cnt;

endmodule

// File: tb/tb_rf_read_port_arbiter.sv
// Directed bench for rf_read_port_arbiter with a combinational R0..R3 mux model.
module tb_rf_read_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [7:0]  req_addr;
  logic [3:0]  req_ready;
  logic [1:0]  mux_addr;
  logic [63:0] mux_data;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [1:0]  rsp_addr;
  logic [63:0] rsp_data;
  logic        rsp_ready;
  logic [7:0]  busy_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  rf_read_port_arbiter #(.DATA_W(64), .ADDR_W(2), .NREQ(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .mux_addr(mux_addr), .mux_data(mux_data),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_addr(rsp_addr),
    .rsp_data(rsp_data), .rsp_ready(rsp_ready), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rval(input logic [1:0] a);
    return {32'hDEAD_BEEF, 30'd0, a};
  endfunction

  assign mux_data = rval(mux_addr);

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] hold_data;

  initial begin
    #100000;
    $display("FAIL watchdog: timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = 4'b0001; req_addr = 8'b0000_0010; rsp_ready = 1'b1;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mux_addr", mux_addr, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy_cnt, 0);
    chk("rst_rsp_data", rsp_data, 0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("t1_ready", req_ready, 4'b0001);
    chk("t1_mux_addr", mux_addr, 2);
    tick();
    req_valid = 4'b0000;
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_id", rsp_id, 0);
    chk("t1_rsp_addr", rsp_addr, 2);
    chk("t1_rsp_data", rsp_data, 64'hDEAD_BEEF_0000_0002);

    // Round robin over all four; requester i uses address 3-i.
    rst_n = 1'b0; #1; rst_n = 1'b1;
    chk("rr_rst_valid", rsp_valid, 0);
    req_addr = {2'd0, 2'd1, 2'd2, 2'd3};
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rr_ready", req_ready, 4'b0001 << (i % 4));
      chk("rr_mux_addr", mux_addr, 3 - (i % 4));
      if (i > 0) begin
        chk("rr_rsp_valid", rsp_valid, 1);
        chk("rr_rsp_id", rsp_id, (i - 1) % 4);
        chk("rr_rsp_data", rsp_data, rval(2'(3 - ((i - 1) % 4))));
      end
      tick();
    end
    chk("rr_last_id", rsp_id, 0);
    chk("rr_last_data", rsp_data, rval(2'd3));

    // Backpressure: pending response, requester 2 waits.
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    hold_data = rsp_data;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ready", req_ready, 0);
      tick();
    end
    chk("bp_busy", busy_cnt, 5);
    chk("bp_valid", rsp_valid, 1);
    chk("bp_id", rsp_id, 0);
    chk("bp_addr", rsp_addr, 3);
    chk("bp_data", rsp_data, hold_data);
    rsp_ready = 1'b1;
    #1;
    chk("bp_rel_ready", req_ready, 4'b0100);
    chk("bp_rel_mux", mux_addr, 1);
    tick();
    req_valid = 4'b0000;
    chk("bp_rsp_id", rsp_id, 2);
    chk("bp_rsp_addr", rsp_addr, 1);
    chk("bp_rsp_data", rsp_data, rval(2'd1));
    chk("bp_busy_hold", busy_cnt, 5);

    // Wrap: requester 1 wins, then 0 before 1 again.
    req_valid = 4'b0010;
    #1;
    chk("wr_ready1", req_ready, 4'b0010);
    tick();
    req_valid = 4'b0011;
    #1;
    chk("wr_ready0", req_ready, 4'b0001);
    chk("wr_rsp_id1", rsp_id, 1);
    tick();
    #1;
    chk("wr_ready1b", req_ready, 4'b0010);
    chk("wr_rsp_id0", rsp_id, 0);
    chk("wr_rsp_data0", rsp_data, rval(2'd3));
    tick();
    req_valid = 4'b0000;
    chk("wr_rsp_id1b", rsp_id, 1);
    tick();
    chk("drain_valid", rsp_valid, 0);
    chk("idle_mux_hold", mux_addr, 2);
    chk("idle_ready", req_ready, 0);

    // Saturation of the stall monitor.
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    tick();
    for (int i = 0; i < 300; i++) tick();
    chk("sat_busy", busy_cnt, 255);
    chk("sat_valid", rsp_valid, 1);

    // Asynchronous reset mid-cycle with a pending response.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", rsp_valid, 0);
    chk("arst_data", rsp_data, 0);
    chk("arst_id", rsp_id, 0);
    chk("arst_busy", busy_cnt, 0);
    chk("arst_ready", req_ready, 0);
    chk("arst_mux", mux_addr, 0);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("arst_prio", req_ready, 4'b0001);
    tick();
    chk("arst_rsp_id", rsp_id, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
